mac_arbiter: RTL and testbench
==============================

Name: mac_arbiter

Overview:
- Shares one pipelined multiply-add unit (DATA_OUT = A*B + C) between NREQ requesters.
- Round-robin grant with a per-requester valid/ready handshake; at most one operand set issued per cycle.
- Tracks each op's owner through the pipeline and returns the result to that requester only.
- Sits between the per-channel processing blocks and the shared MAC datapath; the MAC lives inside as a sub-module.

Parameters:
- WIDTH, default Const (testparametr package, 8): operand width; result is 2*WIDTH.
- NREQ, default 4: number of requesters; legal range 2..8.
- MAC_LAT, default 4: clocks from operand acceptance to result valid; legal range 2..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has an operation pending.
- req_ready  out  NREQ  one-hot grant; a handshake completes when req_valid[i] & req_ready[i] at a rising edge.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_c  in  NREQ*WIDTH  addend C, same packing.
- resp_valid  out  NREQ  one-hot, one-cycle result strobe to the owning requester.
- resp_data  out  2*WIDTH  result, shared by all requesters; qualified by resp_valid.
- busy  out  1  at least one op is in flight.
- grant_id  out  $clog2(NREQ)  index of the current grant; meaningful only when |req_ready.

Behaviour:
- Reset (async assert, sync release), all registers cleared:
  - req_ready=0, resp_valid=0, resp_data=0, busy=0, grant_id=0.
  - rr_ptr=0, pending=0, pipeline valid/tag stages=0.
  - In-flight ops are discarded, and no response is produced for them, including on reset mid-operation.
- Eligibility:
  - elig[i] = req_valid[i] & ~pending[i].
  - Each requester may have at most one op outstanding.
- Arbitration (combinational from elig and rr_ptr):
  - Grant the first eligible index searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is one-hot, or zero when no requester is eligible.
  - req_ready never asserts for a requester with req_valid=0.
- On handshake with requester g at edge t:
  - Operands are captured into the MAC's input stage.
  - Tag g and valid=1 enter the tag shift register (MAC_LAT deep).
  - pending[g] is set.
  - rr_ptr becomes (g+1) mod NREQ. With no grant, rr_ptr holds.
- Response timing:
  - At edge t+MAC_LAT, resp_valid[g] rises for exactly one cycle.
  - resp_data = A*B+C for those operands, registered.
  - pending[g] clears on that same edge, so requester g is eligible again in the response cycle (back-to-back throughput of one op per MAC_LAT+0 cycles per requester).
- Arithmetic:
  - Operands are unsigned; the product is 2*WIDTH wide and C is zero-extended.
  - The sum cannot overflow: max (2^W-1)^2 + 2^W-1 < 2^2W.
- Throughput:
  - One issue per cycle; the pipeline never stalls.
  - Responses are not backpressured; requesters must accept resp_valid unconditionally.
- resp_data holds its last value while resp_valid=0.
- busy = |pending.
- Simultaneous events:
  - A response to i and a new grant to i in the same cycle is legal: the pending set wins over the clear for the new op.
  - Up to min(NREQ, MAC_LAT) ops may be in flight.
- Requester protocol: once req_valid[i] is high, it must stay high with stable operands until the handshake. The arbiter does not check this.

Decomposition:
- testparametr package:
  - Const (width default).
  - NREQ_DEF and MAC_LAT_DEF constants.
  - typedef logic [$clog2(NREQ_DEF)-1:0] req_id_t.
- Sub-module mac_pipe:
  - Inputs: WIDTH, MAC_LAT, clk, rst_n, in_valid, in_tag, a, b, c.
  - Outputs: out_valid, out_tag, out_data, with fixed MAC_LAT latency.
- mac_arbiter holds the round-robin arbiter, the pending bits and the response demux.

Test Plan:
- Single op: reset, then requester 1 issues a=8'd12, b=8'd10, c=8'd5. Handshake at edge t -> resp_valid=4'b0010 at edge t+4 for one cycle, resp_data=16'd125, busy low after it.
- Max values: a=b=c=8'hFF -> resp_data=16'hFF00, no overflow.
- Round-robin: all four requesters hold valid from reset -> grants 0,1,2,3 on consecutive cycles, responses on four consecutive cycles in the same order. Each requester is re-granted in its response cycle.
- Fairness/pointer: requester 0 issues, then requesters 0 and 2 are both eligible with rr_ptr=1 -> 2 is granted before 0.
- Pending block: requester 3 holds valid continuously with its op in flight -> req_ready[3]=0 for cycles t+1..t+3 and asserts again at t+4.
- Reset mid-flight: three ops in flight, rst_n pulsed low for 1 cycle -> all outputs 0 immediately, no resp_valid for the discarded ops, a new op after release completes normally in 4 cycles.

Source files
------------

// File: rtl/testparametr.sv
// Shared constants and types for the MAC arbiter slice.
package testparametr;

  // Default operand width.
  localparam int Const = 8;

  // Default requester count and MAC pipeline depth.
  localparam int NREQ_DEF    = 4;
  localparam int MAC_LAT_DEF = 4;

  // Requester index at the default requester count.
  typedef logic [$clog2(NREQ_DEF)-1:0] req_id_t;

endpackage

// File: rtl/mac_pipe.sv
// Fixed-latency pipelined unsigned multiply-add: out_data = a*b + c.
// An op accepted on edge t appears on out_valid/out_tag/out_data after
// edge t+MAC_LAT-1, so it is sampled by the consumer on edge t+MAC_LAT.
module mac_pipe
  import testparametr::*;
#(
  parameter int WIDTH   = Const,
  parameter int MAC_LAT = MAC_LAT_DEF,
  parameter int TAG_W   = $clog2(NREQ_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               out_valid,
  output logic [TAG_W-1:0]   out_tag,
  output logic [2*WIDTH-1:0] out_data
);

  localparam int RW = 2 * WIDTH;

  logic [MAC_LAT-1:0] vld_q;
  logic [TAG_W-1:0]   tag_q [MAC_LAT];
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   c_q;
  logic [RW-1:0]      res_q [1:MAC_LAT-1];
  logic [RW-1:0]      mac_sum;

  // Multiply-add on the captured operands; C is zero-extended and the sum cannot overflow RW bits.
  always_comb begin
    mac_sum = RW'(a_q) * RW'(b_q) + RW'(c_q);
  end

  // Operand capture stage plus the valid/tag shift register that tracks each op's owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      for (int k = 0; k < MAC_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      vld_q    <= {vld_q[MAC_LAT-2:0], in_valid};
      tag_q[0] <= in_tag;
      for (int k = 1; k < MAC_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
        c_q <= c;
      end
    end
  end

  // Result stages load only behind a valid op, so the last result holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < MAC_LAT; k++) begin
        res_q[k] <= '0;
      end
    end else begin
      if (vld_q[0]) begin
        res_q[1] <= mac_sum;
      end
      for (int k = 2; k < MAC_LAT; k++) begin
        if (vld_q[k-1]) begin
          res_q[k] <= res_q[k-1];
        end
      end
    end
  end

  assign out_valid = vld_q[MAC_LAT-1];
  assign out_tag   = tag_q[MAC_LAT-1];
  assign out_data  = res_q[MAC_LAT-1];

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin sharing of one pipelined multiply-add unit among NREQ requesters.
//
// Handshake: requester i presents req_valid[i] with stable operands until it
// sees req_ready[i] high at a rising edge (req_valid[i] & req_ready[i] = one
// accepted op). req_ready is one-hot or zero and is never high without
// req_valid. Results come back as a one-cycle resp_valid[i] strobe with
// resp_data, exactly MAC_LAT edges after acceptance, with no backpressure.
module mac_arbiter
  import testparametr::*;
#(
  parameter int WIDTH   = Const,
  parameter int NREQ    = NREQ_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*WIDTH-1:0]   req_c,
  output logic [NREQ-1:0]         resp_valid,
  output logic [2*WIDTH-1:0]      resp_data,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]  pending_q;
  logic [NREQ-1:0]  pending_d;
  logic [NREQ-1:0]  pending_eff;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  rr_ptr_d;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  cand;
  logic             gnt_found;
  logic [WIDTH-1:0] gnt_a;
  logic [WIDTH-1:0] gnt_b;
  logic [WIDTH-1:0] gnt_c;
  logic             out_valid;
  logic [ID_W-1:0]  out_tag;
  logic [2*WIDTH-1:0] out_data;

  // Response demux: steer the pipeline's output strobe to the owner recorded in its tag.
  always_comb begin
    resp_valid = '0;
    if (out_valid) begin
      resp_valid = NREQ'(1) << out_tag;
    end
  end

  // A requester whose result is being returned this cycle may issue again now;
  // eligibility is also held off while reset is asserted.
  always_comb begin
    pending_eff = pending_q & ~resp_valid;
    elig        = req_valid & ~pending_eff & {NREQ{rst_n}};
  end

  // Round-robin search from rr_ptr for the first eligible requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    grant     = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = ID_W'((int'(rr_ptr_q) + off) % NREQ);
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_found) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    gnt_a = req_a[gnt_idx*WIDTH +: WIDTH];
    gnt_b = req_b[gnt_idx*WIDTH +: WIDTH];
    gnt_c = req_c[gnt_idx*WIDTH +: WIDTH];
  end

  // Next pending set and pointer: a new grant overrides a same-cycle response clear.
  always_comb begin
    pending_d = pending_eff | grant;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  mac_pipe #(
    .WIDTH   (WIDTH),
    .MAC_LAT (MAC_LAT),
    .TAG_W   (ID_W)
  ) u_mac_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (gnt_found),
    .in_tag    (gnt_idx),
    .a         (gnt_a),
    .b         (gnt_b),
    .c         (gnt_c),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_data  (out_data)
  );

  assign req_ready = grant;
  assign grant_id  = gnt_idx;
  assign resp_data = out_data;
  assign busy      = |pending_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of grants and fixed-latency responses.
module tb_mac_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int L   = 4;
  localparam int IDW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*W-1:0] req_c;
  logic [N-1:0]   resp_valid;
  logic [2*W-1:0] resp_data;
  logic           busy;
  logic [IDW-1:0] grant_id;

  mac_arbiter #(.WIDTH(W), .NREQ(N), .MAC_LAT(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];
  logic [W-1:0] c_v [N];
  logic [N-1:0] reissue;
  int           rand_pct;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
      req_c[i*W +: W] = c_v[i];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [2*W-1:0] exp_q [$];   // expected results, oldest first
  int             tag_m [$];   // owner of each in-flight op
  int             due_q [$];   // edge on which the response is sampled
  int             cyc;         // number of the next rising edge
  int             rr_m;        // next requester to search from
  logic [2*W-1:0] last_data;

  int             hs_edge [N];
  int             rsp_edge_obs [N];
  logic [2*W-1:0] rsp_data_obs [N];
  logic [N-1:0]   rdy_hist [int];
  int             gnt_log [$];
  int             gnt_edge [$];

  int n_assert;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    a_v[i]       = a;
    b_v[i]       = b;
    c_v[i]       = c;
    req_valid[i] = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(7) == 0) return {W{1'b1}};
    return W'($urandom_range(255));
  endfunction

  task automatic raise_rand(input int i);
    raise(i, rnd_op(), rnd_op(), rnd_op());
  endtask

  // One clock: check at the falling edge, apply the rising edge to the model, then update stimulus.
  task automatic step();
    logic [N-1:0] outstanding;
    logic [N-1:0] exp_rv;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] elig;
    logic         exp_busy;
    int           g;
    int           idx;
    int           p;
    @(negedge clk);
    outstanding = '0;
    exp_rv      = '0;
    exp_busy    = 1'b0;
    for (int k = 0; k < due_q.size(); k++) begin
      exp_busy = 1'b1;
      if (due_q[k] == cyc) begin
        exp_rv[tag_m[k]] = 1'b1;
        last_data        = exp_q[k];
      end else begin
        outstanding[tag_m[k]] = 1'b1;
      end
    end
    elig = req_valid & ~outstanding;
    g = -1;
    for (int off = 0; off < N; off++) begin
      idx = (rr_m + off) % N;
      if (g < 0 && elig[idx]) g = idx;
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("resp_valid", resp_valid, exp_rv);
    chk("resp_data", resp_data, last_data);
    chk("busy", busy, exp_busy);
    if (g >= 0) chk("grant_id", grant_id, g);
    rdy_hist[cyc] = req_ready;
    for (int i = 0; i < N; i++) begin
      if (resp_valid[i]) begin
        rsp_edge_obs[i] = cyc;
        rsp_data_obs[i] = resp_data;
      end
      if (req_valid[i] && req_ready[i]) begin
        gnt_log.push_back(i);
        gnt_edge.push_back(cyc);
      end
    end
    @(posedge clk);
    if (g >= 0) begin
      p = int'(a_v[g]) * int'(b_v[g]) + int'(c_v[g]);
      exp_q.push_back((2*W)'(p));
      tag_m.push_back(g);
      due_q.push_back(cyc + L);
      rr_m       = (g + 1) % N;
      hs_edge[g] = cyc;
    end
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(exp_q.pop_front());
      void'(tag_m.pop_front());
      void'(due_q.pop_front());
    end
    cyc++;
    #1;
    if (g >= 0) begin
      if (reissue[g]) raise_rand(g);
      else req_valid[g] = 1'b0;
    end
    if (rand_pct > 0) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(99) < rand_pct) raise_rand(i);
      end
    end
  endtask

  // Entered just after a rising edge; holds reset low across one edge.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    exp_q.delete();
    tag_m.delete();
    due_q.delete();
    rr_m      = 0;
    last_data = '0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t;
    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    rr_m      = 0;
    last_data = '0;
    rand_pct  = 0;
    reissue   = '0;
    req_valid = '0;
    rst_n     = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0; b_v[i] = '0; c_v[i] = '0;
      hs_edge[i] = -100; rsp_edge_obs[i] = -100; rsp_data_obs[i] = '0;
    end
    @(posedge clk);
    #1;
    reset_pulse();
    repeat (2) step();

    // Single op from requester 1.
    raise(1, 8'd12, 8'd10, 8'd5);
    repeat (8) step();
    chk("single_latency", rsp_edge_obs[1] - hs_edge[1], L);
    chk("single_data", rsp_data_obs[1], 16'd125);
    chk("single_busy_after", busy, 0);

    // Largest operands.
    raise(2, 8'hFF, 8'hFF, 8'hFF);
    repeat (8) step();
    chk("max_latency", rsp_edge_obs[2] - hs_edge[2], L);
    chk("max_data", rsp_data_obs[2], 16'hFF00);

    // All four requesters valid out of reset, re-requesting every time.
    for (int i = 0; i < N; i++) raise_rand(i);
    reissue = '1;
    reset_pulse();
    gnt_log.delete();
    gnt_edge.delete();
    repeat (12) step();
    chk("rr_count", gnt_log.size(), 12);
    for (int k = 0; k < 8; k++) begin
      if (gnt_log.size() > k) begin
        chk("rr_order", gnt_log[k], k % N);
        chk("rr_consecutive", gnt_edge[k] - gnt_edge[0], k);
      end
    end
    reissue = '0;
    repeat (8) step();

    // Pointer fairness: after requester 0 issues, 2 wins over 0.
    reset_pulse();
    raise(0, 8'd3, 8'd4, 8'd5);
    repeat (6) step();
    gnt_log.delete();
    raise(0, 8'd7, 8'd7, 8'd7);
    raise(2, 8'd9, 8'd9, 8'd9);
    repeat (8) step();
    chk("fair_count", gnt_log.size(), 2);
    if (gnt_log.size() >= 2) begin
      chk("fair_first", gnt_log[0], 2);
      chk("fair_second", gnt_log[1], 0);
    end

    // Requester 3 holds valid while its op is in flight.
    reissue[3] = 1'b1;
    raise(3, 8'd100, 8'd2, 8'd1);
    step();
    t = hs_edge[3];
    repeat (5) step();
    chk("pend_rdy_t", rdy_hist[t][3], 1);
    for (int k = 1; k < L; k++) chk("pend_blocked", rdy_hist[t+k][3], 0);
    chk("pend_rearm", rdy_hist[t+L][3], 1);
    reissue[3] = 1'b0;
    repeat (6) step();

    // Reset with three ops in flight; a new op afterwards completes normally.
    raise(0, 8'd1, 8'd2, 8'd3);
    raise(1, 8'd4, 8'd5, 8'd6);
    raise(2, 8'd7, 8'd8, 8'd9);
    repeat (3) step();
    chk("mid_busy", busy, 1);
    rsp_edge_obs[1] = -1;
    rsp_edge_obs[2] = -1;
    raise(0, 8'd20, 8'd30, 8'd40);
    reset_pulse();
    repeat (8) step();
    chk("mid_no_resp1", rsp_edge_obs[1], -1);
    chk("mid_no_resp2", rsp_edge_obs[2], -1);
    chk("mid_new_latency", rsp_edge_obs[0] - hs_edge[0], L);
    chk("mid_new_data", rsp_data_obs[0], 16'd640);

    // Randomized traffic: sparse, then saturated with back-to-back reissue.
    rand_pct = 40;
    repeat (300) step();
    reissue  = '1;
    rand_pct = 100;
    repeat (150) step();
    reissue  = '0;
    rand_pct = 0;
    repeat (20) step();
    chk("drain_busy", busy, 0);
    chk("drain_ready", req_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
